// File: rtl/alu_pkg.sv
// Shared types for the cache register file: flush sequencer states and index sizing.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } flush_state_t;

    // Index width for a given entry count, never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth <= 32'd2) ? 32'd1 : 32'($clog2(depth));
    endfunction

endpackage

// File: rtl/cache_read_port.sv
// One combinational operand read port: range check, optional write forwarding, entry mux.
module cache_read_port #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 3,
    parameter bit          BYPASS = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [WIDTH-1:0]  mem_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic              wr_fwd_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_data_c_o,
    output logic              rd_valid_c_o
);

    logic in_range_c;
    logic hit_c;

    assign in_range_c = (32'(rd_addr_i) < DEPTH);
    // wr_fwd_i is only high for a write that will actually commit this cycle.
    assign hit_c      = BYPASS && wr_fwd_i && (wr_addr_i == rd_addr_i);

    always_comb begin
        rd_data_c_o  = '0;
        rd_valid_c_o = 1'b0;
        if (hit_c) begin
            rd_data_c_o  = wr_data_i;
            rd_valid_c_o = 1'b1;
        end else if (in_range_c) begin
            rd_data_c_o  = mem_i[rd_addr_i];
            rd_valid_c_o = valid_i[rd_addr_i];
        end
    end

endmodule

// File: rtl/cache_register_file.sv
// Local operand store for the ALU: DEPTH x WIDTH entries with valid bits, two read
// ports, one write port and a one-entry-per-cycle flush sequencer.
module cache_register_file
    import alu_pkg::*;
#(
    parameter int unsigned  WIDTH  = 16,
    parameter int unsigned  DEPTH  = 8,
    parameter bit           BYPASS = 1'b1,
    localparam int unsigned ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b,
    input  logic              flush_req,
    output logic              busy,
    output logic              flush_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    flush_state_t      state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic              busy_q, done_q;
    logic              wr_ok_c;

    // Flush owns the array while sweeping, and a flush request pre-empts a same-cycle write.
    assign wr_ok_c = wr_en && (state_q != FLUSH) && !flush_req && (32'(wr_addr) < DEPTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == FLUSH);
            done_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (state_q == FLUSH) begin
            mem_q[cnt_q]   <= '0;
            valid_q[cnt_q] <= 1'b0;
        end else if (wr_ok_c) begin
            mem_q[wr_addr]   <= wr_data;
            valid_q[wr_addr] <= 1'b1;
        end
    end

    cache_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .BYPASS(BYPASS)
    ) u_port_a (
        .rd_addr_i   (rd_addr_a),
        .mem_i       (mem_q),
        .valid_i     (valid_q),
        .wr_fwd_i    (wr_ok_c),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_data_c_o (rd_data_a),
        .rd_valid_c_o(rd_valid_a)
    );

    cache_read_port #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .BYPASS(BYPASS)
    ) u_port_b (
        .rd_addr_i   (rd_addr_b),
        .mem_i       (mem_q),
        .valid_i     (valid_q),
        .wr_fwd_i    (wr_ok_c),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .rd_data_c_o (rd_data_b),
        .rd_valid_c_o(rd_valid_b)
    );

    assign busy       = busy_q;
    assign flush_done = done_q;

endmodule

// File: tb/tb_cache_register_file.sv
// Bench for cache_register_file: three configurations (8/bypass, 8/no bypass, 5/bypass)
// driven in lockstep and compared against an array-based reference model.
module tb_cache_register_file;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [15:0] wr_data;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic       flush_req;

    logic [2:0][15:0] rda, rdb;
    logic [2:0]       va, vb, bsy, fdn;

    int checks = 0;
    int passes = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned D = (g == 2) ? 5 : 8;
        localparam bit          B = (g != 1);
        cache_register_file #(
            .WIDTH (16),
            .DEPTH (D),
            .BYPASS(B)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .rd_addr_a (rd_addr_a),
            .rd_data_a (rda[g]),
            .rd_valid_a(va[g]),
            .rd_addr_b (rd_addr_b),
            .rd_data_b (rdb[g]),
            .rd_valid_b(vb[g]),
            .flush_req (flush_req),
            .busy      (bsy[g]),
            .flush_done(fdn[g])
        );
    end

    always #5 clk = ~clk;

    // Reference model: contents per configuration, flush cycles remaining, done pulse.
    int unsigned mdep [3] = '{8, 8, 5};
    bit          mbyp [3] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] mdata [3][8];
    bit          mval  [3][8];
    int unsigned mleft [3];
    bit          mdone [3];

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            for (int a = 0; a < 8; a++) begin
                mdata[d][a] = '0;
                mval[d][a]  = 1'b0;
            end
            mleft[d] = 0;
            mdone[d] = 1'b0;
        end
    endfunction

    function automatic void model_clock();
        for (int d = 0; d < 3; d++) begin
            bit done_n = 1'b0;
            if (mleft[d] != 0) begin
                int unsigned idx = mdep[d] - mleft[d];
                mdata[d][idx] = '0;
                mval[d][idx]  = 1'b0;
                mleft[d]--;
                if (mleft[d] == 0) done_n = 1'b1;
            end else if (flush_req && !mdone[d]) begin
                mleft[d] = mdep[d];
            end else if (wr_en && !flush_req && (32'(wr_addr) < mdep[d])) begin
                mdata[d][wr_addr] = wr_data;
                mval[d][wr_addr]  = 1'b1;
            end
            mdone[d] = done_n;
        end
    endfunction

    function automatic logic [16:0] exp_rd(int d, logic [2:0] addr);
        if (mleft[d] == 0 && mbyp[d] && wr_en && !flush_req &&
            (32'(wr_addr) < mdep[d]) && wr_addr == addr)
            return {1'b1, wr_data};
        if (32'(addr) < mdep[d]) return {mval[d][addr], mdata[d][addr]};
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            rd_addr_b = 3'(7 - i);
            #1;
            checks++;
            if (rda !== '0 || rdb !== '0 || va !== '0 || vb !== '0)
                $display("FAIL reset_read addr=%0d got a=%h/%b b=%h/%b expected all zero",
                         i, rda, va, rdb, vb);
            else passes++;
        end
        checks++;
        if (bsy !== '0 || fdn !== '0)
            $display("FAIL reset_status got busy=%b done=%b expected 000/000", bsy, fdn);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234;
        tick();
        wr_addr = 3'd7; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0; rd_addr_a = 3'd3; rd_addr_b = 3'd7;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rda[d] !== 16'h1234 || va[d] !== 1'b1 || rdb[d] !== 16'hBEEF || vb[d] !== 1'b1)
                $display("FAIL write_read dut=%0d got a=%h/%b b=%h/%b expected 1234/1 beef/1",
                         d, rda[d], va[d], rdb[d], vb[d]);
            else passes++;
        end
        checks++;
        if (rda[2] !== 16'h1234 || va[2] !== 1'b1 || rdb[2] !== 16'h0 || vb[2] !== 1'b0)
            $display("FAIL write_read_d5 got a=%h/%b b=%h/%b expected 1234/1 0000/0",
                     rda[2], va[2], rdb[2], vb[2]);
        else passes++;
        rd_addr_a = 3'd5;
        #1;
        checks++;
        if (rda !== '0 || va !== '0)
            $display("FAIL unwritten_read got %h/%b expected zeros", rda, va);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00AA;
        rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        #1;
        checks++;
        if (rda[0] !== 16'h00AA || va[0] !== 1'b1 || rdb[0] !== 16'h00AA || vb[0] !== 1'b1)
            $display("FAIL bypass_on got a=%h/%b b=%h/%b expected 00aa/1 on both",
                     rda[0], va[0], rdb[0], vb[0]);
        else passes++;
        checks++;
        if (rda[1] !== 16'h0 || va[1] !== 1'b0)
            $display("FAIL bypass_off got %h/%b expected 0000/0", rda[1], va[1]);
        else passes++;
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rda[1] !== 16'h00AA || va[1] !== 1'b1)
            $display("FAIL bypass_off_next got %h/%b expected 00aa/1", rda[1], va[1]);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [15:0] fill [8];
        int b0 = 0, b1 = 0, b2 = 0, d0 = 0, d2 = 0;
        for (int i = 0; i < 8; i++) begin
            fill[i] = 16'($urandom) | 16'h0001;
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = fill[i];
            tick();
        end
        wr_en = 1'b0; flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c == 1) begin
                wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'h5555; rd_addr_a = 3'd1;
                #1;
                checks++;
                if (rda[0] !== fill[1] || va[0] !== 1'b1)
                    $display("FAIL flush_read_stored got %h/%b expected %h/1",
                             rda[0], va[0], fill[1]);
                else passes++;
            end else begin
                wr_en = 1'b0;
            end
            if (bsy[0] === 1'b1) b0++;
            if (bsy[1] === 1'b1) b1++;
            if (bsy[2] === 1'b1) b2++;
            if (fdn[0] === 1'b1) d0++;
            if (fdn[2] === 1'b1) d2++;
            tick();
        end
        checks++;
        if (b0 != 8 || b1 != 8 || b2 != 5)
            $display("FAIL flush_busy_len got %0d/%0d/%0d expected 8/8/5", b0, b1, b2);
        else passes++;
        checks++;
        if (d0 != 1 || d2 != 1)
            $display("FAIL flush_done_pulse got %0d/%0d expected 1/1", d0, d2);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i);
            #1;
            checks++;
            if (rda !== '0 || va !== '0 || rdb !== '0 || vb !== '0)
                $display("FAIL flush_cleared addr=%0d got a=%h/%b expected zeros", i, rda, va);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_collision_abort();
        int pulses = 0;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i += 3) begin
            wr_addr = 3'(i); wr_data = 16'(16'h0100 + i);
            tick();
        end
        wr_addr = 3'd4; wr_data = 16'h7777; flush_req = 1'b1;
        tick();
        wr_en = 1'b0; flush_req = 1'b0;
        checks++;
        if (bsy !== 3'b111)
            $display("FAIL collision_flush_start got busy=%b expected 111", bsy);
        else passes++;
        tick();
        tick();
        rd_addr_a = 3'd4;
        #1;
        checks++;
        if (rda[0] !== 16'h0 || va[0] !== 1'b0)
            $display("FAIL collision_write_dropped got %h/%b expected 0000/0", rda[0], va[0]);
        else passes++;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bsy !== '0 || fdn !== '0)
            $display("FAIL abort_busy got busy=%b done=%b expected 000/000", bsy, fdn);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (fdn !== '0) pulses++;
            tick();
        end
        checks++;
        if (pulses != 0) $display("FAIL abort_no_done got %0d pulses expected 0", pulses);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i); rd_addr_b = 3'(i);
            #1;
            checks++;
            if (rda !== '0 || va !== '0 || rdb !== '0 || vb !== '0)
                $display("FAIL abort_cleared addr=%0d got a=%h/%b expected zeros", i, rda, va);
            else passes++;
        end
        @(negedge clk);
    endtask

    task automatic test_non_pow2();
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666; rd_addr_a = 3'd6;
        #1;
        checks++;
        if (rda[2] !== 16'h0 || va[2] !== 1'b0 || rda[0] !== 16'h6666 || va[0] !== 1'b1)
            $display("FAIL np2_bypass got d5=%h/%b d8=%h/%b expected 0000/0 6666/1",
                     rda[2], va[2], rda[0], va[0]);
        else passes++;
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rda[2] !== 16'h0 || va[2] !== 1'b0 || rda[0] !== 16'h6666 || va[0] !== 1'b1)
            $display("FAIL np2_ignored got d5=%h/%b d8=%h/%b expected 0000/0 6666/1",
                     rda[2], va[2], rda[0], va[0]);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit all_idle = 1'b1;
            for (int d = 0; d < 3; d++)
                if (mleft[d] != 0 || mdone[d]) all_idle = 1'b0;
            wr_en     = ($urandom_range(0, 2) != 0);
            wr_addr   = 3'($urandom);
            wr_data   = 16'($urandom);
            rd_addr_a = ($urandom_range(0, 1) != 0) ? wr_addr : 3'($urandom);
            rd_addr_b = 3'($urandom);
            flush_req = all_idle && ($urandom_range(0, 24) == 0);
            #1;
            for (int d = 0; d < 3; d++) begin
                logic [16:0] ea = exp_rd(d, rd_addr_a);
                logic [16:0] eb = exp_rd(d, rd_addr_b);
                logic        ebusy = (mleft[d] != 0);
                checks++;
                if ({va[d], rda[d]} !== ea || {vb[d], rdb[d]} !== eb)
                    $display("FAIL rand_read n=%0d dut=%0d got a=%h b=%h expected a=%h b=%h",
                             n, d, {va[d], rda[d]}, {vb[d], rdb[d]}, ea, eb);
                else passes++;
                checks++;
                if (bsy[d] !== ebusy || fdn[d] !== mdone[d])
                    $display("FAIL rand_status n=%0d dut=%0d got busy=%b done=%b expected %b/%b",
                             n, d, bsy[d], fdn[d], ebusy, mdone[d]);
                else passes++;
            end
            tick();
        end
        wr_en = 1'b0; flush_req = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 1'b0;
        rst_n = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; flush_req = 1'b0;
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_flush();
        test_collision_abort();
        test_non_pow2();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
